// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive path: FSM state encoding,
// CRC16 seed and the PID nibbles the receive logic cares about.
package usb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } usb_state_t;

    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;

endpackage

// File: rtl/crc_16.sv
// One-byte step of the USB CRC16 (poly 0x8005, processed LSB first, so the
// reflected constant 0xA001 is used). Purely combinational.
module crc_16 (
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] w_c;

    always_comb begin
        w_c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (w_c[0] ^ data_i[i]) begin
                w_c = {1'b0, w_c[15:1]} ^ 16'hA001;
            end else begin
                w_c = {1'b0, w_c[15:1]};
            end
        end
        crc_o = w_c;
    end

endmodule

// File: rtl/usb_rx_crc16_check.sv
// USB receive packet checker: splits off the PID, forwards payload through a
// two-byte delay line so the trailing CRC16 bytes are never forwarded, and
// reports CRC/PID errors with a single end-of-packet pulse.
module usb_rx_crc16_check
    import usb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    input  logic       in_last_i,
    output logic       pid_valid_o,
    output logic [3:0] pid_o,
    output logic       data_valid_o,
    output logic [7:0] data_o,
    output logic       done_o,
    output logic       crc_err_o,
    output logic       pid_err_o,
    output usb_state_t state_o
);

    usb_state_t  r_state;
    usb_state_t  w_state_next;
    logic [1:0]  r_fill;
    logic [7:0]  r_d0;
    logic [7:0]  r_d1;
    logic [15:0] r_crc;
    logic        r_pid_bad;

    logic [15:0] w_crc_next;
    logic        w_accept_pid;
    logic        w_accept_dat;
    logic        w_shift;
    logic        w_end;
    logic [15:0] w_end_crc;
    logic [7:0]  w_tail_lo;
    logic        w_crc_bad;
    logic        w_pid_bad_now;
    logic        w_done;
    logic        w_crc_err;
    logic        w_pid_err;

    // r_d0 is always the oldest byte, so it is the one that leaves the line.
    crc_16 u_crc_16 (
        .crc_i  (r_crc),
        .data_i (r_d0),
        .crc_o  (w_crc_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (in_valid_i) begin
            case (r_state)
                ST_IDLE: w_state_next = in_last_i ? ST_IDLE : ST_DATA;
                ST_DATA: if (in_last_i) w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_accept_pid  = in_valid_i && (r_state == ST_IDLE);
        w_accept_dat  = in_valid_i && (r_state == ST_DATA);
        w_shift       = w_accept_dat && (r_fill == 2'd2);
        w_end         = w_accept_dat && in_last_i;
        w_end_crc     = w_shift ? w_crc_next : r_crc;
        w_tail_lo     = (r_fill == 2'd2) ? r_d1 : r_d0;
        // The CRC is sent inverted, low byte first.
        w_crc_bad     = (r_fill == 2'd0)
                     || (w_tail_lo != ~w_end_crc[7:0])
                     || (in_data_i != ~w_end_crc[15:8]);
        w_pid_bad_now = (in_data_i[7:4] != ~in_data_i[3:0]);
        w_done        = (w_accept_pid && in_last_i) || w_end;
        w_crc_err     = w_end && w_crc_bad;
        w_pid_err     = (w_accept_pid && in_last_i) ? w_pid_bad_now
                                                    : (w_end && r_pid_bad);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fill       <= 2'd0;
            r_d0         <= 8'h00;
            r_d1         <= 8'h00;
            r_crc        <= CRC16_INIT;
            r_pid_bad    <= 1'b0;
            pid_valid_o  <= 1'b0;
            pid_o        <= 4'h0;
            data_valid_o <= 1'b0;
            data_o       <= 8'h00;
            done_o       <= 1'b0;
            crc_err_o    <= 1'b0;
            pid_err_o    <= 1'b0;
        end else begin
            pid_valid_o  <= w_accept_pid;
            data_valid_o <= w_shift;
            done_o       <= w_done;
            crc_err_o    <= w_crc_err;
            pid_err_o    <= w_pid_err;
            if (w_accept_pid) begin
                pid_o     <= in_data_i[3:0];
                r_crc     <= CRC16_INIT;
                r_fill    <= 2'd0;
                r_pid_bad <= w_pid_bad_now;
            end
            if (w_accept_dat) begin
                case (r_fill)
                    2'd0: begin
                        r_d0   <= in_data_i;
                        r_fill <= 2'd1;
                    end
                    2'd1: begin
                        r_d1   <= in_data_i;
                        r_fill <= 2'd2;
                    end
                    default: begin
                        r_d0   <= r_d1;
                        r_d1   <= in_data_i;
                        r_crc  <= w_crc_next;
                        data_o <= r_d0;
                    end
                endcase
            end
        end
    end

    assign state_o = r_state;

endmodule
